sum_sq_seq: RTL and testbench

//   Sequential sum-of-squares engine: accepts n, returns S(n) = sum_{j=0..n} j*j.

---
 rtl/sum_sq_if.sv | 36 +++
 rtl/sum_sq_seq.sv | 112 +++++++++++
 tb/tb_sum_sq_seq.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sum_sq_if.sv
// Request/result handshake bundle for the sequential sum-of-squares engine.
// The master drives requests and accepts results; the slave is the engine.
interface sum_sq_if #(
   parameter int W = 32
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_n;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_ovf;
   logic         busy;

   modport master (
      output in_valid,
      output in_n,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_sum,
      input  out_ovf,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  in_n,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_sum,
      output out_ovf,
      output busy
   );
endinterface

// File: rtl/sum_sq_seq.sv
// Sequential sum-of-squares engine: S(n) = sum j*j for j = 0..n,
// one term per clock through a single multiplier, with overflow flag.
module sum_sq_seq #(
   parameter int W = 32
) (
   input  logic     clk,
   input  logic     rst,
   sum_sq_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [W-1:0] n_q, n_d;
   logic [W-1:0] j_q, j_d;
   logic [W-1:0] acc_q, acc_d;
   logic         ovf_q, ovf_d;
   logic [W-1:0] sum_q, sum_d;
   logic         rovf_q, rovf_d;

   logic [2*W-1:0] sq;
   logic [W:0]     add;
   logic           acc_ovf;
   logic           accept;
   logic           last;
   logic           drain;

   // term product and accumulate; overflow is sticky across the job
   always_comb begin
      sq      = {{W{1'b0}}, j_q} * {{W{1'b0}}, j_q};
      add     = {1'b0, acc_q} + {1'b0, sq[W-1:0]};
      acc_ovf = ovf_q | add[W] | (|sq[2*W-1:W]);
      accept  = (state_q == IDLE) && bus.in_valid;
      last    = (j_q == n_q);
      drain   = (state_q == DONE) && bus.out_ready;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = RUN;
         RUN:  if (last)   state_d = DONE;
         DONE: if (drain)  state_d = IDLE;
         default:          state_d = IDLE;
      endcase
   end

   // index compared before increment, so j never wraps even for n = 2^W-1
   always_comb begin
      n_d    = n_q;
      j_d    = j_q;
      acc_d  = acc_q;
      ovf_d  = ovf_q;
      sum_d  = sum_q;
      rovf_d = rovf_q;
      if (accept) begin
         n_d   = bus.in_n;
         j_d   = '0;
         acc_d = '0;
         ovf_d = 1'b0;
      end else if (state_q == RUN) begin
         acc_d = add[W-1:0];
         ovf_d = acc_ovf;
         if (last) begin
            sum_d  = add[W-1:0];
            rovf_d = acc_ovf;
         end else begin
            j_d = j_q + {{(W-1){1'b0}}, 1'b1};
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         n_q    <= '0;
         j_q    <= '0;
         acc_q  <= '0;
         ovf_q  <= 1'b0;
         sum_q  <= '0;
         rovf_q <= 1'b0;
      end else begin
         n_q    <= n_d;
         j_q    <= j_d;
         acc_q  <= acc_d;
         ovf_q  <= ovf_d;
         sum_q  <= sum_d;
         rovf_q <= rovf_d;
      end
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      bus.busy      = (state_q != IDLE);
      bus.out_sum   = sum_q;
      bus.out_ovf   = rovf_q;
   end

endmodule

// File: tb/tb_sum_sq_seq.sv
// Directed bench for sum_sq_seq: hand-computed sums, latency,
// backpressure, mid-job reset and back-to-back requests.
module tb_sum_sq_seq;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_bad;

   sum_sq_if #(.W(32)) bus ();

   sum_sq_seq #(.W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int k;
      k = 0;
      while (!bus.in_ready && k < 5000) begin
         tick();
         k++;
      end
      if (!bus.in_ready) chk({tag, "_ready_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic wait_valid(input string tag, input int lim,
                             output int cnt);
      cnt = 0;
      while (!bus.out_valid && cnt < lim) begin
         tick();
         cnt++;
      end
      if (!bus.out_valid) chk({tag, "_valid_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic do_job(input string tag, input int unsigned n,
                         input logic [31:0] es, input logic eo);
      int cnt;
      wait_ready(tag);
      bus.in_n     = n;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk({tag, "_busy"}, 64'(bus.busy), 64'd1);
      wait_valid(tag, int'(n) + 10, cnt);
      chk({tag, "_lat"}, 64'(cnt), 64'(n) + 64'd1);
      chk({tag, "_sum"}, 64'(bus.out_sum), 64'(es));
      chk({tag, "_ovf"}, 64'(bus.out_ovf), 64'(eo));
      tick();
      chk({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
   endtask

   initial begin
      int          cnt;
      int unsigned rn;
      logic [63:0] s;

      n_vec         = 0;
      n_bad         = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_n      = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_sum", 64'(bus.out_sum), 64'd0);
      chk("rst_ovf", 64'(bus.out_ovf), 64'd0);
      rst = 1'b0;
      tick();
      chk("rst_ready", 64'(bus.in_ready), 64'd1);

      do_job("n5", 5, 32'd55, 1'b0);
      do_job("n0", 0, 32'd0, 1'b0);
      do_job("n1", 1, 32'd1, 1'b0);

      // result held under backpressure; requests while busy are ignored
      bus.out_ready = 1'b0;
      wait_ready("bp");
      bus.in_n     = 32'd10;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      wait_valid("bp", 20, cnt);
      chk("bp_sum", 64'(bus.out_sum), 64'd385);
      for (int i = 0; i < 10; i++) begin
         bus.in_n     = 32'd7;
         bus.in_valid = (i % 2 == 0);
         tick();
         chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_hold_ready", 64'(bus.in_ready), 64'd0);
         chk("bp_hold_sum", 64'(bus.out_sum), 64'd385);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      chk("bp_release", 64'(bus.out_valid), 64'd0);
      chk("bp_idle", 64'(bus.in_ready), 64'd1);
      do_job("n7", 7, 32'd140, 1'b0);

      do_job("n2000", 2000, 32'd2668667000, 1'b0);
      do_job("n2345", 2345, 32'd6187149, 1'b1);

      // reset in the middle of a long job
      wait_ready("rj");
      bus.in_n     = 32'd100;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (39) tick();
      #2 rst = 1'b1;
      #1;
      chk("rj_valid", 64'(bus.out_valid), 64'd0);
      chk("rj_busy", 64'(bus.busy), 64'd0);
      chk("rj_sum", 64'(bus.out_sum), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      tick();
      do_job("rj_n3", 3, 32'd14, 1'b0);

      // back-to-back with in_valid held high
      wait_ready("b2b");
      bus.in_n     = 32'd2;
      bus.in_valid = 1'b1;
      tick();
      bus.in_n = 32'd4;
      wait_valid("b2b_a", 20, cnt);
      chk("b2b_sum2", 64'(bus.out_sum), 64'd5);
      tick();
      chk("b2b_ready", 64'(bus.in_ready), 64'd1);
      tick();
      bus.in_valid = 1'b0;
      wait_valid("b2b_b", 20, cnt);
      chk("b2b_lat4", 64'(cnt), 64'd5);
      chk("b2b_sum4", 64'(bus.out_sum), 64'd30);
      tick();

      for (int i = 0; i < 8; i++) begin
         rn = (i == 0) ? 32'd3000 : $urandom_range(3000, 0);
         s  = 64'(rn) * (64'(rn) + 64'd1) * (64'd2 * 64'(rn) + 64'd1)
              / 64'd6;
         do_job("rand", rn, s[31:0], s > 64'h0000_0000_FFFF_FFFF);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
